// File: rtl/complex_mux_seq.sv
// -----------------------------------------------------------------------------
// complex_mux_seq
//   N:1 complex-sample multiplexer with a registered, valid/ready-handshaked
//   output. It routes one of NUM_INPUTS {real,imag} channels into the next FFT
//   stage. The channel comes either from the external select or from an
//   internal auto-sequencer. The sequencer steps to the next channel after
//   every BEAT_COUNT accepted beats.
//
// Parameters
//   DATA_WIDTH  bits per real/imag component (two's complement)
//   NUM_INPUTS  number of complex input channels (>=2)
//   BEAT_COUNT  accepted beats per channel before the sequencer advances (>=1)
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_real, in_imag    packed channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid/in_ready   input handshake, in_ready = !out_valid || out_ready
//   select, auto_mode   external select / use internal sequencer
//   restart             clear sequencer to channel 0, beat 0
//   conj                conjugate the selected sample (optional feature)
//   out_real/out_imag   registered selected sample
//   out_chan            channel index that produced the output beat
//   out_valid/out_ready output handshake
//   sel_err             sticky flag: an out-of-range external select was accepted
//
// Optional feature
//   COMPLEX_MUX_CONJ_EN: when defined, conj=1 on accept negates the imaginary
//   part, saturating the most negative value. When undefined, conj is ignored.
// -----------------------------------------------------------------------------
module complex_mux_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 5,
    parameter int BEAT_COUNT = 1,
    localparam int SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_real,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_imag,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SEL_WIDTH-1:0]             select,
    input  logic                             auto_mode,
    input  logic                             restart,
    input  logic                             conj,
    output logic [DATA_WIDTH-1:0]            out_real,
    output logic [DATA_WIDTH-1:0]            out_imag,
    output logic [SEL_WIDTH-1:0]             out_chan,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             sel_err
);

    localparam int BEAT_W = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;

    localparam logic [SEL_WIDTH:0]   NUM_IN_EXT = (SEL_WIDTH+1)'(NUM_INPUTS);
    localparam logic [SEL_WIDTH-1:0] LAST_CHAN  = SEL_WIDTH'(NUM_INPUTS - 1);
    localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BEAT_COUNT - 1);

`ifdef COMPLEX_MUX_CONJ_EN
    // Negation with saturation: the most negative value has no positive
    // counterpart, so it maps to the largest positive value.
    function automatic logic signed [DATA_WIDTH-1:0] sat_neg(
        input logic signed [DATA_WIDTH-1:0] x
    );
        logic signed [DATA_WIDTH-1:0] min_v;
        logic signed [DATA_WIDTH-1:0] max_v;
        min_v = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        max_v = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (x == min_v) begin
            sat_neg = max_v;
        end else begin
            sat_neg = -x;
        end
    endfunction
`endif

    logic [SEL_WIDTH-1:0]         chan_cnt;
    logic [BEAT_W-1:0]            beat_cnt;

    logic                         accept;
    logic [SEL_WIDTH-1:0]         eff_sel;
    logic                         sel_bad;
    logic signed [DATA_WIDTH-1:0] real_p0;
    logic signed [DATA_WIDTH-1:0] sel_imag_p0;
    logic signed [DATA_WIDTH-1:0] imag_p0;

    logic signed [DATA_WIDTH-1:0] real_p1;
    logic signed [DATA_WIDTH-1:0] imag_p1;
    logic [SEL_WIDTH-1:0]         chan_p1;
    logic                         vld_p1;
    logic                         err_q;

    // ---- stage p0: handshake, channel selection, optional conjugate ----
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign eff_sel  = auto_mode ? chan_cnt : select;
    // The sequencer never leaves the valid range, so only an external select
    // can be out of range.
    assign sel_bad  = !auto_mode && ({1'b0, select} >= NUM_IN_EXT);

    // An out-of-range select matches no channel and yields zero.
    always_comb begin
        real_p0     = '0;
        sel_imag_p0 = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (eff_sel == SEL_WIDTH'(k)) begin
                real_p0     = in_real[k*DATA_WIDTH +: DATA_WIDTH];
                sel_imag_p0 = in_imag[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef COMPLEX_MUX_CONJ_EN
    assign imag_p0 = conj ? sat_neg(sel_imag_p0) : sel_imag_p0;
`else
    logic unused_conj;
    assign unused_conj = conj;
    assign imag_p0     = sel_imag_p0;
`endif

    // ---- sequencer: advances on auto-mode accepts; restart has priority ----
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_cnt <= '0;
            beat_cnt <= '0;
        end else if (restart) begin
            chan_cnt <= '0;
            beat_cnt <= '0;
        end else if (accept && auto_mode) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
                chan_cnt <= (chan_cnt == LAST_CHAN) ? '0 : chan_cnt + 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // ---- stage p1: output register, holds while stalled ----
    always_ff @(posedge clk) begin
        if (rst) begin
            real_p1 <= '0;
            imag_p1 <= '0;
            chan_p1 <= '0;
            vld_p1  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                real_p1 <= real_p0;
                imag_p1 <= imag_p0;
                chan_p1 <= eff_sel;
                vld_p1  <= 1'b1;
                if (sel_bad) begin
                    err_q <= 1'b1;
                end
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_real  = real_p1;
    assign out_imag  = imag_p1;
    assign out_chan  = chan_p1;
    assign out_valid = vld_p1;
    assign sel_err   = err_q;

endmodule
